spectrum_frame_sched: RTL

Frame scheduler for the spectrum-display path. It sits between the FFT magnitude-squared stream and the `log_scale` datapath and decides which FFT frames are converted. It regenerates frame framing for `log_scale` from its own bin count and captures the 8-bit log results into a ping-pong frame buffer. Completed frames are handed to the display reader with a ready/ack handshake.

---
 rtl/spec_sched_pkg.sv | 15 +
 rtl/spec_frame_ram.sv | 35 +++
 rtl/spectrum_frame_sched.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/spec_sched_pkg.sv
// Shared types for the spectrum frame scheduler.
//   in_state_t : input-side frame FSM state
//   bank_t     : ping-pong bank index (RAM address MSB)
//   OVF_W      : width of the dropped-frame counter
package spec_sched_pkg;
    typedef enum logic [1:0] {
        ST_SYNC,
        ST_SKIP,
        ST_PASS
    } in_state_t;

    typedef logic bank_t;

    localparam int OVF_W = 16;
endpackage

// File: rtl/spec_frame_ram.sv
// Ping-pong frame buffer, 2 x NUM_BINS x 8, bank bit is the address MSB.
// Ports:
//   clk, rst_n          : clock, async active-low reset (read register only)
//   wr_en/bank/addr/data: write port, written on the clock edge
//   rd_bank, rd_addr    : read address, rd_data registered one cycle later
module spec_frame_ram
    import spec_sched_pkg::*;
#(
    parameter int NUM_BINS = 1024,
    localparam int AW = $clog2(NUM_BINS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  bank_t         wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  bank_t         rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);
    logic [7:0] r_mem [0:2*NUM_BINS-1];
    logic [7:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (wr_en) r_mem[{wr_bank, wr_addr}] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rd_data <= '0;
        else        r_rd_data <= r_mem[{rd_bank, rd_addr}];
    end

    assign rd_data = r_rd_data;
endmodule

// File: rtl/spectrum_frame_sched.sv
// Frame scheduler between the FFT |X|^2 stream and log_scale. Selects one
// frame in DECIM, regenerates framing from its own bin count, captures the
// 8-bit log results into a ping-pong buffer and hands completed frames to the
// display with frame_ready / frame_ack.
// Ports:
//   s_mag_*      : FFT input stream (no backpressure)
//   lg_mag_*     : forwarded stream to log_scale, 1 registered cycle
//   lg_log_*     : log_scale results, written to the write bank
//   rd_addr/data : display read port on the display bank, 1-cycle latency
//   frame_ready/frame_ack : display handshake
//   err_len      : 1-cycle pulse on a frame-length error
//   ovf_cnt      : saturating count of selected frames dropped for no bank
//   peak_bin/val : per-frame maximum, only with SPEC_FRAME_STATS_EN defined
// Optional feature macro: SPEC_FRAME_STATS_EN (peak tracker).
//
// state | meaning
// SYNC  | discard beats until a last beat re-establishes framing
// SKIP  | frame not selected, beats counted but not forwarded
// PASS  | frame selected, every beat forwarded to log_scale
module spectrum_frame_sched
    import spec_sched_pkg::*;
#(
    parameter int NUM_BINS = 1024,
    parameter int DECIM    = 4,
    localparam int AW = $clog2(NUM_BINS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      s_mag_data,
    input  logic             s_mag_valid,
    input  logic             s_mag_last,
    output logic [31:0]      lg_mag_squared,
    output logic             lg_mag_valid,
    output logic             lg_mag_last,
    input  logic [7:0]       lg_log_out,
    input  logic             lg_log_valid,
    input  logic             lg_log_last,
    input  logic [AW-1:0]    rd_addr,
    output logic [7:0]       rd_data,
    output logic             frame_ready,
    input  logic             frame_ack,
    output logic             err_len,
    output logic [OVF_W-1:0] ovf_cnt,
    output logic [AW-1:0]    peak_bin,
    output logic [7:0]       peak_val
);
    localparam int IW = (DECIM > 1) ? $clog2(DECIM) : 1;

    in_state_t        r_state;
    logic [IW-1:0]    r_frame_idx;
    logic [AW-1:0]    r_bin_cnt;
    logic [31:0]      r_lg_data;
    logic             r_lg_valid, r_lg_last, r_err_len, r_bad_mark;
    logic [OVF_W-1:0] r_ovf_cnt;

    logic [AW-1:0]    r_cap_addr;
    logic             r_inflight, r_bad, r_last_q, r_last_bad_q;
    logic             r_pending, r_repub, r_frame_ready;
    bank_t            r_wr_bank;

    logic [IW-1:0]    w_idx_base, w_idx_next;
    logic             w_last_bin, w_sel, w_pass_ok;
    logic             w_ack, w_cap, w_cap_last, w_disp_idle, w_publish_new;

    // The SYNC-terminating frame counts as index 0.
    always_comb begin
        w_idx_base = (r_state == ST_SYNC) ? '0 : r_frame_idx;
        w_idx_next = (w_idx_base == IW'(DECIM - 1)) ? '0 : w_idx_base + IW'(1);
        w_sel      = (w_idx_next == '0);
        w_pass_ok  = w_sel && !r_pending && !r_inflight;
        w_last_bin = (r_bin_cnt == AW'(NUM_BINS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_SYNC;
            r_frame_idx <= '0;
            r_bin_cnt   <= '0;
            r_lg_data   <= '0;
            r_lg_valid  <= 1'b0;
            r_lg_last   <= 1'b0;
            r_err_len   <= 1'b0;
            r_bad_mark  <= 1'b0;
            r_ovf_cnt   <= '0;
        end else begin
            r_lg_valid <= 1'b0;
            r_lg_last  <= 1'b0;
            r_err_len  <= 1'b0;
            r_bad_mark <= 1'b0;
            if (s_mag_valid) begin
                if (r_state == ST_PASS) begin
                    r_lg_valid <= 1'b1;
                    r_lg_data  <= s_mag_data;
                    r_lg_last  <= s_mag_last || w_last_bin;
                end
                if (r_state != ST_SYNC && w_last_bin && !s_mag_last) begin
                    // Overlong frame: framing lost, resynchronise.
                    r_err_len  <= 1'b1;
                    r_bad_mark <= (r_state == ST_PASS);
                    r_bin_cnt  <= '0;
                    r_state    <= ST_SYNC;
                end else if (s_mag_last) begin
                    r_err_len   <= (r_state != ST_SYNC) && !w_last_bin;
                    r_bad_mark  <= (r_state == ST_PASS) && !w_last_bin;
                    r_bin_cnt   <= '0;
                    r_frame_idx <= w_idx_next;
                    r_state     <= w_pass_ok ? ST_PASS : ST_SKIP;
                    if (w_sel && !w_pass_ok && r_ovf_cnt != '1)
                        r_ovf_cnt <= r_ovf_cnt + OVF_W'(1);
                end else if (r_state != ST_SYNC) begin
                    r_bin_cnt <= r_bin_cnt + AW'(1);
                end
            end
        end
    end

    // Results are only accepted for a frame this block forwarded, so a stale
    // log_scale stream after reset never reaches the buffer.
    always_comb begin
        w_ack         = frame_ack && r_frame_ready;
        w_cap         = lg_log_valid && r_inflight;
        w_cap_last    = w_cap && lg_log_last;
        w_disp_idle   = (!r_frame_ready || w_ack) && !r_repub;
        w_publish_new = r_last_q && !r_last_bad_q && w_disp_idle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_addr    <= '0;
            r_inflight    <= 1'b0;
            r_bad         <= 1'b0;
            r_last_q      <= 1'b0;
            r_last_bad_q  <= 1'b0;
            r_pending     <= 1'b0;
            r_repub       <= 1'b0;
            r_frame_ready <= 1'b0;
            r_wr_bank     <= 1'b0;
        end else begin
            if (w_cap) r_cap_addr <= lg_log_last ? '0 : r_cap_addr + AW'(1);
            r_last_q     <= w_cap_last;
            r_last_bad_q <= r_bad;
            if (r_bad_mark) r_bad <= 1'b1;
            if (w_cap_last) r_bad <= 1'b0;
            if (r_lg_valid)    r_inflight <= 1'b1;
            else if (r_last_q) r_inflight <= 1'b0;

            // Ack first; a pending frame swaps in now and rises next cycle.
            r_repub <= 1'b0;
            if (w_ack) begin
                r_frame_ready <= 1'b0;
                if (r_pending) begin
                    r_wr_bank <= ~r_wr_bank;
                    r_pending <= 1'b0;
                    r_repub   <= 1'b1;
                end
            end
            if (r_repub) r_frame_ready <= 1'b1;
            if (w_publish_new) begin
                r_wr_bank     <= ~r_wr_bank;
                r_frame_ready <= 1'b1;
            end else if (r_last_q && !r_last_bad_q) begin
                r_pending <= 1'b1;
            end
        end
    end

    spec_frame_ram #(.NUM_BINS(NUM_BINS)) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_cap),
        .wr_bank (r_wr_bank),
        .wr_addr (r_cap_addr),
        .wr_data (lg_log_out),
        .rd_bank (~r_wr_bank),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

`ifdef SPEC_FRAME_STATS_EN
    logic [7:0]    r_trk_val, r_peak_val;
    logic [AW-1:0] r_trk_bin, r_peak_bin;

    // Strict compare keeps the lowest index on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trk_val  <= '0;
            r_trk_bin  <= '0;
            r_peak_val <= '0;
            r_peak_bin <= '0;
        end else begin
            if (w_cap && (r_cap_addr == '0 || lg_log_out > r_trk_val)) begin
                r_trk_val <= lg_log_out;
                r_trk_bin <= r_cap_addr;
            end
            if (w_publish_new || r_repub) begin
                r_peak_val <= r_trk_val;
                r_peak_bin <= r_trk_bin;
            end
        end
    end

    assign peak_val = r_peak_val;
    assign peak_bin = r_peak_bin;
`else
    assign peak_val = '0;
    assign peak_bin = '0;
`endif

    assign lg_mag_squared = r_lg_data;
    assign lg_mag_valid   = r_lg_valid;
    assign lg_mag_last    = r_lg_last;
    assign err_len        = r_err_len;
    assign ovf_cnt        = r_ovf_cnt;
    assign frame_ready    = r_frame_ready;
endmodule
